// File: rtl/hit_arbiter_ctrl_if.sv
// Game-controller bus: button/collision inputs and life-counter/LED outputs.
interface hit_arbiter_ctrl_if #(
    parameter int NUM_SRC = 4
);
    logic               start;
    logic [NUM_SRC-1:0] hit_req;
    logic               hit_out;
    logic [2:0]         hit_src;
    logic [1:0]         lives;
    logic               restart;
    logic               playing;
    logic               grace_active;
    logic               blink;
    logic               game_over;

    // Stimulus side: drives button and collision levels, observes status.
    modport master (
        output start, hit_req,
        input  hit_out, hit_src, lives, restart, playing, grace_active, blink, game_over
    );

    // Controller side.
    modport slave (
        input  start, hit_req,
        output hit_out, hit_src, lives, restart, playing, grace_active, blink, game_over
    );
endinterface

// File: rtl/hit_arbiter_ctrl.sv
// Hit arbiter and game sequencer: round-robin grant of collision rises,
// one-cycle hit pulses, invincibility window with LED blink, game-over and
// restart sequencing for the downstream life counter.
module hit_arbiter_ctrl #(
    parameter int NUM_SRC      = 4,
    parameter int LIVES        = 3,
    parameter int GRACE_CYCLES = 50000000,
    parameter int BLINK_DIV    = 6250000
) (
    input logic              clk,
    input logic              rst,
    hit_arbiter_ctrl_if.slave bus
);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GW = $clog2(GRACE_CYCLES);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GRACE, S_OVER} state_t;

    state_t             state, state_nxt;
    logic               start_q;
    logic [NUM_SRC-1:0] hit_q;
    logic [IW-1:0]      rr_ptr, rr_nxt;
    logic [GW-1:0]      grace_cnt, grace_nxt;
    logic [BW-1:0]      blink_cnt, blink_cnt_nxt;
    logic               blink, blink_nxt;
    logic               hit_out, hit_out_nxt;
    logic [2:0]         hit_src, hit_src_nxt;
    logic [1:0]         lives, lives_nxt;
    logic               restart, restart_nxt;

    logic               start_rise;
    logic [NUM_SRC-1:0] hit_rise;
    logic               grant_vld;
    logic [IW-1:0]      grant_idx;

    assign start_rise = bus.start & ~start_q;
    assign hit_rise   = bus.hit_req & ~hit_q;

    // Round-robin search: first rising source at or above rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_vld && hit_rise[(int'(rr_ptr) + k) % NUM_SRC]) begin
                grant_vld = 1'b1;
                grant_idx = IW'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        grace_nxt     = grace_cnt;
        blink_cnt_nxt = blink_cnt;
        blink_nxt     = blink;
        lives_nxt     = lives;
        hit_src_nxt   = hit_src;
        hit_out_nxt   = 1'b0;
        restart_nxt   = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                // start wins over any same-cycle hit; hits are never granted here
                if (start_rise) begin
                    state_nxt   = S_PLAY;
                    lives_nxt   = 2'(LIVES);
                    restart_nxt = 1'b1;
                    blink_nxt   = 1'b0;
                end
            end
            S_PLAY: begin
                if (grant_vld) begin
                    hit_out_nxt = 1'b1;
                    hit_src_nxt = 3'(grant_idx);
                    lives_nxt   = lives - 2'd1;
                    rr_nxt      = (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + IW'(1);
                    if (lives == 2'd1) begin
                        state_nxt = S_OVER;
                    end else begin
                        state_nxt     = S_GRACE;
                        grace_nxt     = GW'(GRACE_CYCLES - 1);
                        blink_nxt     = 1'b1;
                        blink_cnt_nxt = BW'(BLINK_DIV - 1);
                    end
                end
            end
            S_GRACE: begin
                // rises during grace are discarded; hit_q still tracks so held levels don't retrigger
                if (grace_cnt == '0) begin
                    state_nxt = S_PLAY;
                    blink_nxt = 1'b0;
                end else begin
                    grace_nxt = grace_cnt - GW'(1);
                    if (blink_cnt == '0) begin
                        blink_nxt     = ~blink;
                        blink_cnt_nxt = BW'(BLINK_DIV - 1);
                    end else begin
                        blink_cnt_nxt = blink_cnt - BW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers; edge-detect history updates in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            hit_q     <= '0;
            rr_ptr    <= '0;
            grace_cnt <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            hit_out   <= 1'b0;
            hit_src   <= 3'd0;
            lives     <= 2'(LIVES);
            restart   <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= bus.start;
            hit_q     <= bus.hit_req;
            rr_ptr    <= rr_nxt;
            grace_cnt <= grace_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink     <= blink_nxt;
            hit_out   <= hit_out_nxt;
            hit_src   <= hit_src_nxt;
            lives     <= lives_nxt;
            restart   <= restart_nxt;
        end
    end

    assign bus.hit_out      = hit_out;
    assign bus.hit_src      = hit_src;
    assign bus.lives        = lives;
    assign bus.restart      = restart;
    assign bus.blink        = blink;
    assign bus.playing      = (state == S_PLAY) || (state == S_GRACE);
    assign bus.grace_active = (state == S_GRACE);
    assign bus.game_over    = (state == S_OVER);
endmodule

// File: tb/tb_hit_arbiter_ctrl.sv
// Scoreboard bench: stimulus queues expected hit/restart events, a negedge
// monitor pops and compares whenever hit_out or restart is presented.
module tb_hit_arbiter_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hit_arbiter_ctrl_if #(.NUM_SRC(4)) bus ();

    hit_arbiter_ctrl #(
        .NUM_SRC(4), .LIVES(3), .GRACE_CYCLES(8), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic [2:0] src;
        logic [1:0] lives;
        logic       over;
    } hexp_t;

    hexp_t      hq[$];
    logic [1:0] rq[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic nc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every presented hit pulse / restart pulse must match the head of its queue.
    hexp_t      he;
    logic [1:0] re;
    always @(negedge clk) begin
        if (bus.hit_out) begin
            if (hq.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL hit_unexpected: got hit_out=1 src=%0d expected no hit", bus.hit_src);
            end else begin
                he = hq.pop_front();
                chk("hit_src",   int'(bus.hit_src),      int'(he.src));
                chk("hit_lives", int'(bus.lives),        int'(he.lives));
                chk("hit_over",  int'(bus.game_over),    int'(he.over));
                chk("hit_grace", int'(bus.grace_active), int'(!he.over));
            end
        end
        if (bus.restart) begin
            if (rq.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL restart_unexpected: got restart=1 expected none");
            end else begin
                re = rq.pop_front();
                chk("restart_lives",   int'(bus.lives),     int'(re));
                chk("restart_playing", int'(bus.playing),   1);
                chk("restart_over",    int'(bus.game_over), 0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    int bexp [8] = '{1, 1, 0, 0, 1, 1, 0, 0};

    // Directed stimulus.
    initial begin
        bus.start   = 1'b0;
        bus.hit_req = 4'b0000;
        nc(2);
        chk("rst_lives",   int'(bus.lives), 3);
        chk("rst_hit_out", int'(bus.hit_out), 0);
        chk("rst_hit_src", int'(bus.hit_src), 0);
        chk("rst_restart", int'(bus.restart), 0);
        chk("rst_playing", int'(bus.playing), 0);
        chk("rst_grace",   int'(bus.grace_active), 0);
        chk("rst_blink",   int'(bus.blink), 0);
        chk("rst_over",    int'(bus.game_over), 0);
        rst = 1'b1;
        nc(1);

        // start from IDLE
        bus.start = 1'b1; rq.push_back(2'd3);
        nc(1);
        chk("t1_playing", int'(bus.playing), 1);
        bus.start = 1'b0;
        nc(1);
        chk("t1_playing2", int'(bus.playing), 1);
        chk("t1_lives",    int'(bus.lives), 3);

        // simultaneous 1010 with rr_ptr=0 -> source 1, bit 3 dropped
        bus.hit_req = 4'b1010; hq.push_back('{3'd1, 2'd2, 1'b0});
        nc(1); bus.hit_req = 4'b0000;
        nc(1); bus.hit_req = 4'b0001;   // rise during grace: ignored
        nc(1); bus.hit_req = 4'b0000;
        nc(6);
        chk("t3_back_play",  int'(bus.playing), 1);
        chk("t3_grace_off",  int'(bus.grace_active), 0);
        chk("t3_lives",      int'(bus.lives), 2);
        // next 1010 rise -> round-robin gives source 3
        bus.hit_req = 4'b1010; hq.push_back('{3'd3, 2'd1, 1'b0});
        nc(1); bus.hit_req = 4'b0001;   // rises in grace and is held past grace end
        nc(8);
        chk("t4_play_held", int'(bus.playing), 1);
        nc(3);
        chk("t4_lives_held", int'(bus.lives), 1);
        bus.hit_req = 4'b0000;
        nc(1);
        bus.hit_req = 4'b0001; hq.push_back('{3'd0, 2'd0, 1'b1});  // last life
        nc(1);
        chk("t5_over",  int'(bus.game_over), 1);
        chk("t5_grace", int'(bus.grace_active), 0);
        bus.hit_req = 4'b0000;
        nc(1); bus.hit_req = 4'b0100;   // hit in OVER: ignored
        nc(2);
        chk("t5_over_hold", int'(bus.game_over), 1);
        chk("t5_lives0",    int'(bus.lives), 0);
        bus.hit_req = 4'b0000;
        bus.start = 1'b1; rq.push_back(2'd3);
        nc(1);
        chk("t5_restart_play", int'(bus.playing), 1);
        bus.start = 1'b0;

        // rr_ptr=1: 0100 -> source 2; blink pattern through grace
        bus.hit_req = 4'b0100; hq.push_back('{3'd2, 2'd2, 1'b0});
        for (int i = 0; i < 8; i++) begin
            nc(1);
            chk("t2_grace", int'(bus.grace_active), 1);
            chk("t2_blink", int'(bus.blink), bexp[i]);
            if (i == 0) bus.hit_req = 4'b0000;
        end
        nc(1);
        chk("t2_grace_end", int'(bus.grace_active), 0);
        chk("t2_playing",   int'(bus.playing), 1);
        chk("t2_blink_off", int'(bus.blink), 0);

        // rr_ptr=3: 0001 -> source 0 (wrap), then 1000 -> source 3, game over
        bus.hit_req = 4'b0001; hq.push_back('{3'd0, 2'd1, 1'b0});
        nc(1); bus.hit_req = 4'b0000;
        nc(8);
        bus.hit_req = 4'b1000; hq.push_back('{3'd3, 2'd0, 1'b1});
        nc(1);
        chk("t5b_over", int'(bus.game_over), 1);
        bus.hit_req = 4'b0000;
        nc(1);
        bus.start = 1'b1; rq.push_back(2'd3);
        nc(1);
        bus.start = 1'b0;
        chk("t5b_lives", int'(bus.lives), 3);

        // async reset mid-grace
        bus.hit_req = 4'b0010; hq.push_back('{3'd1, 2'd2, 1'b0});
        nc(1); bus.hit_req = 4'b0000;
        nc(2);
        chk("t6_in_grace", int'(bus.grace_active), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_grace",   int'(bus.grace_active), 0);
        chk("t6_playing", int'(bus.playing), 0);
        chk("t6_blink",   int'(bus.blink), 0);
        chk("t6_lives",   int'(bus.lives), 3);
        chk("t6_hit_src", int'(bus.hit_src), 0);
        nc(1); rst = 1'b1;
        nc(1); bus.hit_req = 4'b0001;   // hit in IDLE: ignored
        nc(3);
        chk("t6_idle_lives",   int'(bus.lives), 3);
        chk("t6_idle_playing", int'(bus.playing), 0);
        bus.hit_req = 4'b0000;
        nc(2);
        chk("hit_queue_left",     hq.size(), 0);
        chk("restart_queue_left", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
